// File: rtl/decodificador_display.sv
// Display loopback checker: decodes three 7-segment buses back to a decimal value,
// debounces the pattern triple and verifies it follows the free-running count.
module decodificador_display #(
   parameter int unsigned STABLE_CYCLES = 3,
   parameter int unsigned MAX_VALUE     = 255,
   parameter int unsigned ERR_W         = 16
) (
   input  logic             reloj,
   input  logic             reset,
   input  logic [6:0]       seg_cen,
   input  logic [6:0]       seg_dec,
   input  logic [6:0]       seg_uni,
   output logic [9:0]       valor,
   output logic             valor_valido,
   output logic             patron_invalido,
   output logic             error_secuencia,
   output logic             sincronizado,
   output logic [ERR_W-1:0] cuenta_errores
);

   localparam int unsigned CW       = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] STAB_MAX = CW'(STABLE_CYCLES);
   localparam logic [CW-1:0] STAB_PRE = CW'(STABLE_CYCLES - 1);
   localparam logic [9:0]    MAX_V    = 10'(MAX_VALUE);

   typedef enum logic {IDLE, TRACK} estado_t;

   estado_t         estado;
   logic [20:0]     muestra;
   logic [CW-1:0]   stab_cnt;

   logic [20:0]     entrada;
   logic            nuevo, acepta, digitos_ok, fuera_seq;
   logic [4:0]      dc, dd, du;
   logic [9:0]      v, esperado;

   // Returns {valid, digit}; anything outside the ten glyphs (blank included) is invalid.
   function automatic logic [4:0] decodifica(input logic [6:0] s);
      case (s)
         7'h7E:   return {1'b1, 4'd0};
         7'h30:   return {1'b1, 4'd1};
         7'h6D:   return {1'b1, 4'd2};
         7'h79:   return {1'b1, 4'd3};
         7'h33:   return {1'b1, 4'd4};
         7'h5B:   return {1'b1, 4'd5};
         7'h5F:   return {1'b1, 4'd6};
         7'h70:   return {1'b1, 4'd7};
         7'h7F:   return {1'b1, 4'd8};
         7'h7B:   return {1'b1, 4'd9};
         default: return 5'd0;
      endcase
   endfunction

   always_comb begin
      entrada    = {seg_cen, seg_dec, seg_uni};
      // stab_cnt==0 only after reset, so a triple held across reset release starts a fresh run
      nuevo      = (entrada != muestra) || (stab_cnt == '0);
      acepta     = nuevo ? (STABLE_CYCLES == 1) : (stab_cnt == STAB_PRE);
      dc         = decodifica(seg_cen);
      dd         = decodifica(seg_dec);
      du         = decodifica(seg_uni);
      digitos_ok = dc[4] & dd[4] & du[4];
      v          = 10'(dc[3:0]) * 10'd100 + 10'(dd[3:0]) * 10'd10 + 10'(du[3:0]);
      esperado   = (valor == MAX_V) ? '0 : valor + 10'd1;
      fuera_seq  = (v != esperado) || (v > MAX_V);
   end

   always_ff @(posedge reloj) begin
      if (!reset) begin
         estado          <= IDLE;
         muestra         <= '0;
         stab_cnt        <= '0;
         valor           <= '0;
         valor_valido    <= 1'b0;
         patron_invalido <= 1'b0;
         error_secuencia <= 1'b0;
         sincronizado    <= 1'b0;
         cuenta_errores  <= '0;
      end else begin
         valor_valido    <= 1'b0;
         patron_invalido <= 1'b0;
         error_secuencia <= 1'b0;

         if (nuevo) begin
            muestra  <= entrada;
            stab_cnt <= CW'(1);
         end else if (stab_cnt != STAB_MAX) begin
            stab_cnt <= stab_cnt + CW'(1);
         end

         if (acepta) begin
            if (!digitos_ok) begin
               patron_invalido <= 1'b1;
               estado          <= IDLE;
               sincronizado    <= 1'b0;
               if (cuenta_errores != '1)
                  cuenta_errores <= cuenta_errores + ERR_W'(1);
            end else begin
               valor        <= v;
               valor_valido <= 1'b1;
               estado       <= TRACK;
               sincronizado <= 1'b1;
               if (estado == TRACK && fuera_seq) begin
                  error_secuencia <= 1'b1;
                  if (cuenta_errores != '1)
                     cuenta_errores <= cuenta_errores + ERR_W'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_decodificador_display.sv
// Directed bench for decodificador_display: table of held triples with expected outcomes,
// a full count sweep with wrap, and a mid-run reset; a second instance checks ERR_W=2 saturation.
module tb_decodificador_display;

   logic        reloj = 1'b0;
   logic        reset = 1'b0;
   logic [6:0]  seg_cen = 7'h7E, seg_dec = 7'h7E, seg_uni = 7'h7E;
   logic [9:0]  valor, valor2;
   logic        valor_valido, patron_invalido, error_secuencia, sincronizado;
   logic        vv2, pi2, es2, sync2;
   logic [15:0] cuenta_errores;
   logic [1:0]  cuenta2;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [6:0] segtab [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                               7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

   typedef struct {
      logic [20:0] pat;
      int          n;
      int          valor;
      int          vv;
      int          pi;
      int          es;
      int          sync;
      int          err;
   } vec_t;

   vec_t tbl [12];

   always #5 reloj = ~reloj;

   decodificador_display #(.STABLE_CYCLES(3), .MAX_VALUE(255), .ERR_W(16)) dut (
      .reloj(reloj), .reset(reset),
      .seg_cen(seg_cen), .seg_dec(seg_dec), .seg_uni(seg_uni),
      .valor(valor), .valor_valido(valor_valido), .patron_invalido(patron_invalido),
      .error_secuencia(error_secuencia), .sincronizado(sincronizado),
      .cuenta_errores(cuenta_errores)
   );

   decodificador_display #(.STABLE_CYCLES(3), .MAX_VALUE(255), .ERR_W(2)) dut2 (
      .reloj(reloj), .reset(reset),
      .seg_cen(seg_cen), .seg_dec(seg_dec), .seg_uni(seg_uni),
      .valor(valor2), .valor_valido(vv2), .patron_invalido(pi2),
      .error_secuencia(es2), .sincronizado(sync2),
      .cuenta_errores(cuenta2)
   );

   function automatic logic [20:0] enc(input int v);
      return {segtab[v / 100], segtab[(v / 10) % 10], segtab[v % 10]};
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic hold(input logic [20:0] pat, input int n,
                       output int vv, output int pi, output int es);
      {seg_cen, seg_dec, seg_uni} = pat;
      vv = 0; pi = 0; es = 0;
      repeat (n) begin
         @(posedge reloj);
         #1;
         vv += int'(valor_valido);
         pi += int'(patron_invalido);
         es += int'(error_secuencia);
      end
   endtask

   task automatic run_row(input string tag, input vec_t r);
      int vv, pi, es;
      hold(r.pat, r.n, vv, pi, es);
      chk({tag, " valor"}, int'(valor), r.valor);
      chk({tag, " valor_valido"}, vv, r.vv);
      chk({tag, " patron_invalido"}, pi, r.pi);
      chk({tag, " error_secuencia"}, es, r.es);
      chk({tag, " sincronizado"}, int'(sincronizado), r.sync);
      chk({tag, " cuenta_errores"}, int'(cuenta_errores), r.err);
      chk({tag, " cuenta_errores_w2"}, int'(cuenta2), (r.err > 3) ? 3 : r.err);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, " valor"}, int'(valor), 0);
      chk({tag, " valor_valido"}, int'(valor_valido), 0);
      chk({tag, " patron_invalido"}, int'(patron_invalido), 0);
      chk({tag, " error_secuencia"}, int'(error_secuencia), 0);
      chk({tag, " sincronizado"}, int'(sincronizado), 0);
      chk({tag, " cuenta_errores"}, int'(cuenta_errores), 0);
      chk({tag, " cuenta_errores_w2"}, int'(cuenta2), 0);
   endtask

   initial begin
      int vv, pi, es, total_vv, total_es;
      vec_t r;

      //             pattern                        n  valor vv pi es sync err
      tbl[0]  = '{enc(43),                         3, 43,   1, 0, 1, 1,   1};
      tbl[1]  = '{enc(44),                         3, 44,   1, 0, 0, 1,   1};
      tbl[2]  = '{enc(46),                         2, 44,   0, 0, 0, 1,   1};
      tbl[3]  = '{enc(45),                         3, 45,   1, 0, 0, 1,   1};
      tbl[4]  = '{{7'h7E, 7'h00, 7'h5B},           3, 45,   0, 1, 0, 0,   2};
      tbl[5]  = '{enc(1),                          3, 1,    1, 0, 0, 1,   2};
      tbl[6]  = '{enc(999),                        3, 999,  1, 0, 1, 1,   3};
      tbl[7]  = '{21'h0,                           3, 999,  0, 1, 0, 0,   4};
      tbl[8]  = '{enc(1),                          3, 1,    1, 0, 0, 1,   4};
      tbl[9]  = '{{7'h7F, 7'h7F, 7'h01},           3, 1,    0, 1, 0, 0,   5};
      tbl[10] = '{enc(1),                          1, 1,    0, 0, 0, 0,   5};
      tbl[11] = '{enc(1),                          2, 1,    1, 0, 0, 1,   5};

      // Reset held with 000 on the buses
      repeat (2) @(posedge reloj);
      #1;
      check_reset("reset");
      reset = 1'b1;

      r = '{enc(0), 3, 0, 1, 0, 0, 1, 0};
      run_row("first_zero", r);
      r = '{enc(0), 4, 0, 0, 0, 0, 1, 0};
      run_row("hold_zero", r);

      // Full count with wrap 255 -> 0
      total_vv = 1;
      total_es = 0;
      for (int i = 1; i <= 256; i++) begin
         int val;
         val = i % 256;
         hold(enc(val), 5, vv, pi, es);
         total_vv += vv;
         total_es += es;
         chk($sformatf("sweep %0d valor", val), int'(valor), val);
         chk($sformatf("sweep %0d pulses", val), vv, 1);
      end
      chk("sweep total valor_valido", total_vv, 257);
      chk("sweep error_secuencia", total_es, 0);
      chk("sweep cuenta_errores", int'(cuenta_errores), 0);

      for (int i = 1; i <= 41; i++)
         hold(enc(i), 5, vv, pi, es);
      chk("climb valor", int'(valor), 41);
      chk("climb sincronizado", int'(sincronizado), 1);

      for (int k = 0; k < 12; k++)
         run_row($sformatf("row%0d", k), tbl[k]);

      // Reset with a run pending: the run must restart after release
      hold(enc(2), 2, vv, pi, es);
      chk("pending no event", vv + pi + es, 0);
      reset = 1'b0;
      @(posedge reloj);
      #1;
      check_reset("midreset");
      reset = 1'b1;
      hold(enc(2), 2, vv, pi, es);
      chk("post reset short run", vv + pi + es, 0);
      r = '{enc(2), 1, 2, 1, 0, 0, 1, 0};
      run_row("post reset accept", r);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
